// File: rtl/load_store_unit.sv
// RV32I load/store sequencer in front of a word-wide synchronous data memory.
// Sub-word stores use read-modify-write; loads are lane-selected and extended here.

module lsu_lane_merge (
  input  logic [7:0] old_b,
  input  logic [7:0] new_b,
  input  logic       sel,
  output logic [7:0] out_b
);
  assign out_b = sel ? new_b : old_b;
endmodule

module load_store_unit #(
  parameter int MEM_AW      = 8,
  parameter bit RANGE_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rd
);

  localparam int NUM_LANES = 4;
  localparam logic [31:0] HI_MASK = ~((32'd1 << (MEM_AW + 2)) - 32'd1);

  typedef enum logic [2:0] {
    IDLE, LD_RD, LD_CAP, ST_RD, ST_MRG, ST_WR, RESP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        is_store_q, is_store_d;
  logic        fault_q, fault_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic [31:0] rdata_q, rdata_d;

  // Accept-time legality: alignment, funct3 encoding, address range.
  logic f3_bad, misalign, out_of_range, acc_fault;

  always_comb begin
    if (is_store) f3_bad = (funct3[2] == 1'b1) || (funct3[1:0] == 2'b11);
    else          f3_bad = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    misalign     = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    out_of_range = RANGE_CHECK && ((addr & HI_MASK) != 32'd0);
    acc_fault    = f3_bad || misalign || out_of_range;
  end

  // Byte-lane merge for SB/SH: SB hits one lane, SH hits the lane pair picked by addr[1].
  logic [NUM_LANES-1:0][7:0] old_lanes, new_lanes, mrg_lanes;
  logic [NUM_LANES-1:0]      lane_sel;

  assign old_lanes = mem_rd;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam logic [1:0] LANE = 2'(l);
    assign lane_sel[l]  = funct3_q[0] ? (LANE[1] == addr_q[1]) : (LANE == addr_q[1:0]);
    assign new_lanes[l] = (funct3_q[0] && LANE[0]) ? wdata_q[15:8] : wdata_q[7:0];
    lsu_lane_merge u_merge (
      .old_b (old_lanes[l]),
      .new_b (new_lanes[l]),
      .sel   (lane_sel[l]),
      .out_b (mrg_lanes[l])
    );
  end

  // Load extraction and extension
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    ld_byte = mem_rd[{addr_q[1:0], 3'b000} +: 8];
    ld_half = mem_rd[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_rd;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    is_store_d = is_store_q;
    fault_d    = fault_q;
    wbuf_d     = wbuf_q;
    rdata_d    = rdata_q;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_wd     = 32'd0;
    mem_a      = (state_q == IDLE) ? 32'd0 : {addr_q[31:2], 2'b00};
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d     = addr;
          wdata_d    = wdata;
          funct3_d   = funct3;
          is_store_d = is_store;
          fault_d    = acc_fault;
          if (acc_fault)                 state_d = RESP;
          else if (!is_store)            state_d = LD_RD;
          else if (funct3[1:0] == 2'b10) state_d = ST_WR;
          else                           state_d = ST_RD;
        end
      end
      LD_RD: begin
        mem_re  = 1'b1;
        state_d = LD_CAP;
      end
      LD_CAP: begin
        if (!is_store_q) rdata_d = ld_ext;
        state_d = RESP;
      end
      ST_RD: begin
        mem_re  = 1'b1;
        state_d = ST_MRG;
      end
      ST_MRG: begin
        wbuf_d  = mrg_lanes;
        state_d = ST_WR;
      end
      ST_WR: begin
        mem_we  = 1'b1;
        mem_wd  = (funct3_q[1:0] == 2'b10) ? wdata_q : wbuf_q;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      funct3_q   <= 3'd0;
      is_store_q <= 1'b0;
      fault_q    <= 1'b0;
      wbuf_q     <= 32'd0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      funct3_q   <= funct3_d;
      is_store_q <= is_store_d;
      fault_q    <= fault_d;
      wbuf_q     <= wbuf_d;
      rdata_q    <= rdata_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign done      = (state_q == RESP);
  assign fault     = (state_q == RESP) && fault_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory behind it.

module tb_load_store_unit;

  logic        clk, rst_n, req, req_ready, is_store, done, fault, mem_we, mem_re;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata, mem_a, mem_wd, mem_rd;

  load_store_unit #(.MEM_AW(8), .RANGE_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_ready(req_ready),
    .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
    .done(done), .fault(fault), .rdata(rdata),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_re(mem_re), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read memory; read data is garbage when mem_re was low.
  logic [31:0] mem [0:255];
  int re_cnt = 0, we_cnt = 0, both_cnt = 0, wd_bad = 0, done_cnt = 0;

  always @(posedge clk) begin
    if (mem_we) mem[mem_a[9:2]] <= mem_wd;
    mem_rd <= mem_re ? mem[mem_a[9:2]] : 32'hBAD0BAD0;
    if (mem_re) re_cnt <= re_cnt + 1;
    if (mem_we) we_cnt <= we_cnt + 1;
    if (done)   done_cnt <= done_cnt + 1;
  end

  always @(negedge clk) begin
    if (mem_re && mem_we)        both_cnt <= both_cnt + 1;
    if (!mem_we && mem_wd != 0)  wd_bad <= wd_bad + 1;
  end

  int vecs = 0, errs = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request from IDLE; returns done latency, fault, rdata and memory-strobe counts.
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int lat, output logic flt,
                       output logic [31:0] rd, output int nre, output int nwe);
    int re0, we0;
    @(negedge clk);
    re0 = re_cnt; we0 = we_cnt;
    req = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h5A5A_5A5A; funct3 = 3'b111; is_store = ~st;
    lat = 0; flt = 1'b0; rd = 32'd0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i; flt = fault; rd = rdata;
        break;
      end
    end
    @(negedge clk);
    nre = re_cnt - re0; nwe = we_cnt - we0;
  endtask

  int lat, nre, nwe, busy, dn, idx;
  logic flt;
  logic [31:0] rd, last_rd;

  typedef struct { logic st; logic [2:0] f3; logic [31:0] a; logic [31:0] wd; logic [31:0] exp; } op_t;
  op_t hs [4];

  initial begin
    rst_n = 1'b0; req = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_done",  {31'd0, done},      32'd0);
    chk("rst_fault", {31'd0, fault},     32'd0);
    chk("rst_strb",  {30'd0, mem_we, mem_re}, 32'd0);
    chk("rst_mem_a", mem_a,  32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    chk("rst_rdata", rdata,  32'd0);
    rst_n = 1'b1;

    // SW then LW
    do_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, flt, rd, nre, nwe);
    chk("sw_lat", 32'(lat), 32'd2); chk("sw_fault", {31'd0, flt}, 32'd0);
    chk("sw_nre", 32'(nre), 32'd0); chk("sw_nwe", 32'(nwe), 32'd1);
    do_op(1'b0, 3'b010, 32'h10, 32'h0, lat, flt, rd, nre, nwe);
    chk("lw_lat", 32'(lat), 32'd3); chk("lw_fault", {31'd0, flt}, 32'd0);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_nre", 32'(nre), 32'd1); chk("lw_nwe", 32'(nwe), 32'd0);

    // Sub-word read-modify-write
    do_op(1'b1, 3'b010, 32'h20, 32'h11223344, lat, flt, rd, nre, nwe);
    do_op(1'b1, 3'b000, 32'h21, 32'hFFFF_FFAA, lat, flt, rd, nre, nwe);
    chk("sb_lat", 32'(lat), 32'd4); chk("sb_nre", 32'(nre), 32'd1); chk("sb_nwe", 32'(nwe), 32'd1);
    chk("sb_rdata_kept", rd, 32'hDEADBEEF);
    do_op(1'b0, 3'b010, 32'h20, 32'h0, lat, flt, rd, nre, nwe);
    chk("sb_readback", rd, 32'h1122AA44);
    do_op(1'b1, 3'b001, 32'h22, 32'h1234BEEF, lat, flt, rd, nre, nwe);
    chk("sh_lat", 32'(lat), 32'd4);
    do_op(1'b0, 3'b010, 32'h20, 32'h0, lat, flt, rd, nre, nwe);
    chk("sh_readback", rd, 32'hBEEFAA44);

    // Load extension
    do_op(1'b1, 3'b010, 32'h30, 32'h80FF7F80, lat, flt, rd, nre, nwe);
    do_op(1'b0, 3'b000, 32'h30, 32'h0, lat, flt, rd, nre, nwe); chk("lb0",  rd, 32'hFFFFFF80);
    do_op(1'b0, 3'b100, 32'h30, 32'h0, lat, flt, rd, nre, nwe); chk("lbu0", rd, 32'h00000080);
    do_op(1'b0, 3'b001, 32'h32, 32'h0, lat, flt, rd, nre, nwe); chk("lh2",  rd, 32'hFFFF80FF);
    do_op(1'b0, 3'b101, 32'h32, 32'h0, lat, flt, rd, nre, nwe); chk("lhu2", rd, 32'h000080FF);
    do_op(1'b0, 3'b000, 32'h31, 32'h0, lat, flt, rd, nre, nwe); chk("lb1",  rd, 32'h0000007F);
    do_op(1'b0, 3'b100, 32'h32, 32'h0, lat, flt, rd, nre, nwe); chk("lbu2", rd, 32'h000000FF);
    last_rd = rd;

    // Faults: done at cycle 1, no memory traffic, rdata untouched
    do_op(1'b0, 3'b010, 32'h102, 32'h0, lat, flt, rd, nre, nwe);
    chk("f_lw_mis_lat", 32'(lat), 32'd1); chk("f_lw_mis", {31'd0, flt}, 32'd1);
    chk("f_lw_mis_mem", 32'(nre + nwe), 32'd0); chk("f_rdata_kept", rd, last_rd);
    do_op(1'b1, 3'b001, 32'h3, 32'h0, lat, flt, rd, nre, nwe);
    chk("f_sh_mis_lat", 32'(lat), 32'd1); chk("f_sh_mis", {31'd0, flt}, 32'd1);
    chk("f_sh_mis_mem", 32'(nre + nwe), 32'd0);
    do_op(1'b0, 3'b011, 32'h0, 32'h0, lat, flt, rd, nre, nwe);
    chk("f_f3_lat", 32'(lat), 32'd1); chk("f_f3", {31'd0, flt}, 32'd1);
    chk("f_f3_mem", 32'(nre + nwe), 32'd0);
    do_op(1'b1, 3'b100, 32'h0, 32'h0, lat, flt, rd, nre, nwe);
    chk("f_st_f3", {31'd0, flt}, 32'd1);
    do_op(1'b0, 3'b010, 32'h400, 32'h0, lat, flt, rd, nre, nwe);
    chk("f_range_lat", 32'(lat), 32'd1); chk("f_range", {31'd0, flt}, 32'd1);
    chk("f_range_mem", 32'(nre + nwe), 32'd0);
    do_op(1'b0, 3'b010, 32'h3FC, 32'h0, lat, flt, rd, nre, nwe);
    chk("top_word_ok", {31'd0, flt}, 32'd0);

    // Handshake: req held high, alternating SW/LW
    hs[0] = '{1'b1, 3'b010, 32'h40, 32'h12345678, 32'h0};
    hs[1] = '{1'b0, 3'b010, 32'h40, 32'h0,        32'h12345678};
    hs[2] = '{1'b1, 3'b010, 32'h44, 32'hCAFEF00D, 32'h0};
    hs[3] = '{1'b0, 3'b010, 32'h44, 32'h0,        32'hCAFEF00D};
    busy = 0; dn = 0; idx = 0;
    @(negedge clk);
    req = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge clk);
      if (done) begin
        chk("hs_fault", {31'd0, fault}, 32'd0);
        if (!hs[dn].st) chk("hs_rdata", rdata, hs[dn].exp);
        dn++;
      end
      if (!req_ready) busy++;
      if (dn == 4) break;
      if (req_ready && idx < 4) begin
        is_store = hs[idx].st; funct3 = hs[idx].f3; addr = hs[idx].a; wdata = hs[idx].wd;
        idx++;
      end
    end
    req = 1'b0;
    chk("hs_dones", 32'(dn), 32'd4);
    chk("hs_busy", 32'(busy), 32'd10);
    repeat (3) @(negedge clk);
    chk("hs_no_extra", {31'd0, done}, 32'd0);

    // Reset during ST_MRG of an SB
    do_op(1'b1, 3'b010, 32'h60, 32'h55667788, lat, flt, rd, nre, nwe);
    nwe = we_cnt; dn = done_cnt;
    @(negedge clk);
    req = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 32'h61; wdata = 32'hEE;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);  // ST_RD
    @(negedge clk);  // ST_MRG
    rst_n = 1'b0;
    #1;
    chk("mr_ready", {31'd0, req_ready}, 32'd1);
    chk("mr_strb",  {29'd0, done, mem_we, mem_re}, 32'd0);
    chk("mr_mem_a", mem_a, 32'd0);
    chk("mr_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mr_no_we", 32'(we_cnt - nwe), 32'd0);
    chk("mr_no_done", 32'(done_cnt - dn), 32'd0);
    do_op(1'b0, 3'b010, 32'h60, 32'h0, lat, flt, rd, nre, nwe);
    chk("mr_old_word", rd, 32'h55667788);

    chk("re_we_overlap", 32'(both_cnt), 32'd0);
    chk("wd_outside_wr", 32'(wd_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
